// File: rtl/vector_pkg.sv
// Shared vector-unit types.
// - fp16_t       : raw IEEE half-precision bit pattern, never interpreted here.
// - valu_op_t    : VALU opcode; VOP_NOP (0) is the idle value on the operand bus.
// - vseq_state_t : valu_sequencer control states.
// - VALU_LATENCY : VALU pipeline depth, default for valu_sequencer.VALU_LAT.
package vector_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [2:0] {
    VOP_NOP = 3'd0,
    VOP_ADD = 3'd1,
    VOP_SUB = 3'd2,
    VOP_MUL = 3'd3,
    VOP_MIN = 3'd4,
    VOP_MAX = 3'd5
  } valu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vseq_state_t;

  localparam int unsigned VALU_LATENCY = 2;

  // Index width for n elements; never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/valu_lat_pipe.sv
// 1-bit valid delay line matching the VALU pipeline depth.
// Ports:
// - clk_i   : clock
// - rst_ni  : asynchronous active-low reset, clears every stage
// - valid_i : operand-valid presented to the VALU this cycle
// - valid_o : valid_i delayed by Lat cycles (a plain wire when Lat == 0)
module valu_lat_pipe #(
  parameter int unsigned Lat = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic valid_o
);

  if (Lat == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign valid_o        = valid_i;
  end else begin : g_pipe
    logic [Lat-1:0] pipe_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= valid_i;
        for (int unsigned i = 1; i < Lat; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign valid_o = pipe_q[Lat-1];
  end

endmodule

// File: rtl/valu_sequencer.sv
// Issue-side sequencer for the VALU. Accepts one whole-vector operation, streams element
// pairs onto the VALU operand bus one per cycle, collects the in-order result stream after
// the fixed VALU latency and returns the assembled destination vector.
// Ports:
// - CLK, nRST              : clock, asynchronous active-low reset
// - req_valid/req_ready    : request handshake; req_op, req_va, req_vb latched on accept
// - vdat1, vdat2, vop      : VALU operand bus, zero outside ISSUE
// - result                 : VALU result, valid VALU_LAT cycles after its operands
// - rsp_valid/rsp_ready    : response handshake; rsp_vd is the result buffer
// - busy                   : high whenever the sequencer is not IDLE
// Element i of any vector occupies bits [16i+15:16i].
module valu_sequencer
  import vector_pkg::*;
#(
  parameter int unsigned VLEN     = 8,
  parameter int unsigned VALU_LAT = VALU_LATENCY
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                req_valid,
  output logic                req_ready,
  input  valu_op_t            req_op,
  input  logic [VLEN*16-1:0]  req_va,
  input  logic [VLEN*16-1:0]  req_vb,
  output fp16_t               vdat1,
  output fp16_t               vdat2,
  output valu_op_t            vop,
  input  fp16_t               result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [VLEN*16-1:0]  rsp_vd,
  output logic                busy
);

  localparam int unsigned    IW      = idx_width(VLEN);
  localparam logic [IW-1:0]  LastIdx = IW'(VLEN - 1);

  vseq_state_t             state_q, state_d;
  valu_op_t                op_q;
  logic [VLEN-1:0][15:0]   va_q, vb_q, vd_q;
  logic [IW-1:0]           issue_idx_q, issue_idx_d;
  logic [IW-1:0]           wb_idx_q, wb_idx_d;
  logic                    accept;
  logic                    issue;
  logic                    wb_valid;
  logic                    wb_last;

  // Tracks which cycles carry a real result back from the VALU; results arrive in order so
  // the writeback index alone places them.
  valu_lat_pipe #(
    .Lat (VALU_LAT)
  ) u_lat_pipe (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .valid_i (issue),
    .valid_o (wb_valid)
  );

  assign accept  = (state_q == IDLE) && req_valid;
  assign issue   = (state_q == ISSUE);
  assign wb_last = wb_valid && (wb_idx_q == LastIdx);
  assign busy    = (state_q != IDLE);
  assign rsp_vd  = vd_q;

  always_comb begin
    state_d     = state_q;
    issue_idx_d = issue_idx_q;
    wb_idx_d    = wb_idx_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    vdat1       = '0;
    vdat2       = '0;
    vop         = VOP_NOP;

    // Writeback can complete in any state; the index stops at the last element.
    if (wb_valid && (wb_idx_q != LastIdx)) begin
      wb_idx_d = wb_idx_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d     = ISSUE;
          issue_idx_d = '0;
          wb_idx_d    = '0;
        end
      end
      ISSUE: begin
        vdat1 = va_q[issue_idx_q];
        vdat2 = vb_q[issue_idx_q];
        vop   = op_q;
        if (issue_idx_q == LastIdx) begin
          // With a combinational VALU the last result is captured in this same cycle.
          state_d = (VALU_LAT > 0) ? DRAIN : DONE;
        end else begin
          issue_idx_d = issue_idx_q + 1'b1;
        end
      end
      DRAIN: begin
        if (wb_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      op_q        <= VOP_NOP;
      va_q        <= '0;
      vb_q        <= '0;
      vd_q        <= '0;
      issue_idx_q <= '0;
      wb_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      issue_idx_q <= issue_idx_d;
      wb_idx_q    <= wb_idx_d;
      if (accept) begin
        op_q <= req_op;
        va_q <= req_va;
        vb_q <= req_vb;
      end
      // The buffer is not cleared per operation: rsp_vd keeps the last vector until
      // the next operation overwrites it element by element.
      if (wb_valid) begin
        vd_q[wb_idx_q] <= result;
      end
    end
  end

endmodule
